// File: rtl/axi_tremolo_param_regs.sv
// AXI4-Lite slave holding the four tremolo parameter registers.
// Writes honour byte strobes and emit a one-cycle reload strobe per register.
module axi_tremolo_param_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   param0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   param1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   param2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   param3,
   output logic [3:0]                      param_upd
);
   // state  | meaning
   // W_IDLE | waiting for AW+W; awready_q high marks the accept cycle
   // W_RESP | BVALID held until BREADY
   // R_IDLE | waiting for AR; arready_q high marks the accept cycle
   // R_DATA | RVALID held with stable RDATA/RRESP until RREADY
   localparam int         DW     = C_S_AXI_DATA_WIDTH;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t       w_state, w_state_nxt;
   r_state_t       r_state, r_state_nxt;
   logic           awready_q, awready_nxt, bvalid_q, bvalid_nxt, wr_en;
   logic [1:0]     bresp_q, bresp_nxt, rresp_q, rresp_nxt;
   logic           arready_q, arready_nxt, rvalid_q, rvalid_nxt, rd_en;
   logic [DW-1:0]  rdata_q, rdata_nxt;
   logic [DW-1:0]  regs [4];
   logic [3:0]     upd_q;
   logic           aw_oor, ar_oor;
   logic [1:0]     aw_idx, ar_idx;
   logic           unused_ok;

   // Anything above the 16-byte window is outside the register map.
   assign aw_oor = (S_AXI_AWADDR >> 4) != '0;
   assign ar_oor = (S_AXI_ARADDR >> 4) != '0;
   assign aw_idx = S_AXI_AWADDR[3:2];
   assign ar_idx = S_AXI_ARADDR[3:2];
   assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   always_comb begin
      w_state_nxt = w_state;
      awready_nxt = 1'b0;
      bvalid_nxt  = bvalid_q;
      bresp_nxt   = bresp_q;
      wr_en       = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (awready_q) begin
               if (S_AXI_AWVALID && S_AXI_WVALID) begin
                  wr_en       = 1'b1;
                  bvalid_nxt  = 1'b1;
                  bresp_nxt   = aw_oor ? SLVERR : OKAY;
                  w_state_nxt = W_RESP;
               end
            end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
               awready_nxt = 1'b1;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               bvalid_nxt  = 1'b0;
               w_state_nxt = W_IDLE;
            end
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nxt = r_state;
      arready_nxt = 1'b0;
      rvalid_nxt  = rvalid_q;
      rdata_nxt   = rdata_q;
      rresp_nxt   = rresp_q;
      rd_en       = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (arready_q) begin
               if (S_AXI_ARVALID) begin
                  rd_en       = 1'b1;
                  rvalid_nxt  = 1'b1;
                  // regs still holds the pre-write value on a same-edge write
                  rdata_nxt   = ar_oor ? '0 : regs[ar_idx];
                  rresp_nxt   = ar_oor ? SLVERR : OKAY;
                  r_state_nxt = R_DATA;
               end
            end else if (S_AXI_ARVALID) begin
               arready_nxt = 1'b1;
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) begin
               rvalid_nxt  = 1'b0;
               r_state_nxt = R_IDLE;
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state   <= W_IDLE;
         r_state   <= R_IDLE;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
      end else begin
         w_state   <= w_state_nxt;
         r_state   <= r_state_nxt;
         awready_q <= awready_nxt;
         bvalid_q  <= bvalid_nxt;
         bresp_q   <= bresp_nxt;
         arready_q <= arready_nxt;
         rvalid_q  <= rvalid_nxt;
         rdata_q   <= rdata_nxt;
         rresp_q   <= rresp_nxt;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         upd_q <= '0;
      end else begin
         upd_q <= '0;
         if (wr_en && !aw_oor) begin
            for (int k = 0; k < DW/8; k++) begin
               if (S_AXI_WSTRB[k]) regs[aw_idx][8*k +: 8] <= S_AXI_WDATA[8*k +: 8];
            end
            if (|S_AXI_WSTRB) upd_q[aw_idx] <= 1'b1;
         end
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign param0        = regs[0];
   assign param1        = regs[1];
   assign param2        = regs[2];
   assign param3        = regs[3];
   assign param_upd     = upd_q;
endmodule

// File: tb/tb_axi_tremolo_param_regs.sv
// Scoreboard bench for axi_tremolo_param_regs: stimulus pushes expected
// responses, a negedge monitor pops them on each B/R handshake and strobe.
module tb_axi_tremolo_param_regs;
   logic        ACLK, ARESET;
   logic [7:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
   logic [1:0]  BRESP, RRESP;
   logic [31:0] RDATA, param0, param1, param2, param3;
   logic [3:0]  param_upd;

   axi_tremolo_param_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(AWREADY),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(WREADY),
      .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(ARREADY),
      .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(rready),
      .param0(param0), .param1(param1), .param2(param2), .param3(param3), .param_upd(param_upd)
   );

   typedef struct packed { logic [1:0] resp; logic [127:0] params; } b_exp_t;
   typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_exp_t;

   b_exp_t     exp_b [$];
   r_exp_t     exp_r [$];
   logic [3:0] exp_upd [$];
   logic [31:0] mdl [4];
   int vectors = 0;
   int miscompares = 0;

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Reference model: a plain array of four words with byte-lane merge.
   task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
      b_exp_t e;
      if (addr >= 8'h10) begin
         e.resp = 2'b10;
      end else begin
         e.resp = 2'b00;
         for (int k = 0; k < 4; k++)
            if (strb[k]) mdl[addr[3:2]][8*k +: 8] = data[8*k +: 8];
         if (strb != 4'h0) exp_upd.push_back(4'b0001 << addr[3:2]);
      end
      e.params = {mdl[3], mdl[2], mdl[1], mdl[0]};
      exp_b.push_back(e);
   endtask

   task automatic model_read(input logic [7:0] addr);
      r_exp_t e;
      e.data = (addr >= 8'h10) ? 32'h0 : mdl[addr[3:2]];
      e.resp = (addr >= 8'h10) ? 2'b10 : 2'b00;
      exp_r.push_back(e);
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb, input int wdly);
      int n;
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1;
      for (int i = 0; i < wdly; i++) begin
         @(posedge ACLK); #1;
         chk("no_accept_before_w", {AWREADY, WREADY, BVALID}, 0);
      end
      wvalid = 1'b1;
      n = 0;
      do begin @(posedge ACLK); #1; n++; end while (!(AWREADY && WREADY) && n < 20);
      if (!(AWREADY && WREADY)) begin
         fail("aw_w_ready_timeout");
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      @(posedge ACLK); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      chk("ready_one_cycle", {AWREADY, WREADY}, 0);
      n = 0;
      while (BVALID && n < 50) begin @(posedge ACLK); #1; n++; end
      if (BVALID) fail("b_handshake_timeout");
   endtask

   task automatic do_read(input logic [7:0] addr);
      int n;
      araddr = addr; arvalid = 1'b1;
      n = 0;
      do begin @(posedge ACLK); #1; n++; end while (!ARREADY && n < 20);
      if (!ARREADY) begin
         fail("arready_timeout");
         arvalid = 1'b0;
         return;
      end
      @(posedge ACLK); #1;
      arvalid = 1'b0;
      chk("arready_one_cycle", ARREADY, 0);
      n = 0;
      while (RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
      if (RVALID) fail("r_handshake_timeout");
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb, input int wdly);
      model_write(addr, data, strb);
      do_write(addr, data, strb, wdly);
   endtask

   task automatic rd(input logic [7:0] addr);
      model_read(addr);
      do_read(addr);
   endtask

   always @(negedge ACLK) begin
      if (!ARESET) begin
         if (BVALID && bready) begin
            if (exp_b.size() == 0) fail("unexpected_b");
            else begin
               b_exp_t e;
               e = exp_b.pop_front();
               chk("bresp", BRESP, e.resp);
               chk("params_at_b", {param3, param2, param1, param0}, e.params);
            end
         end
         if (RVALID && rready) begin
            if (exp_r.size() == 0) fail("unexpected_r");
            else begin
               r_exp_t e;
               e = exp_r.pop_front();
               chk("rdata", RDATA, e.data);
               chk("rresp", RRESP, e.resp);
            end
         end
         if (param_upd != 4'h0) begin
            if (exp_upd.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL param_upd_unexpected: got 0x%0h expected none at %0t", param_upd, $time);
            end else chk("param_upd", param_upd, exp_upd.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a;
      ARESET = 1'b1;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;
      chk("reset_ctrl", {AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, param_upd}, 0);
      chk("reset_rdata", RDATA, 0);
      chk("reset_params", {param3, param2, param1, param0}, 0);

      for (int i = 0; i < 4; i++) wr(8'(4*i), 32'(i+1), 4'hF, 0);
      for (int i = 0; i < 4; i++) rd(8'(4*i));
      chk("seq_params", {param3, param2, param1, param0}, {32'h4, 32'h3, 32'h2, 32'h1});

      wr(8'h4, 32'hFFFF_FFFF, 4'hF, 0);
      wr(8'h4, 32'h0000_00AA, 4'h1, 0);
      rd(8'h4);
      chk("byte_lane_param1", param1, 32'hFFFF_FFAA);

      wr(8'h8, 32'h1234_5678, 4'hF, 5);
      chk("late_w_param2", param2, 32'h1234_5678);

      // B backpressure with a second write waiting on the bus
      bready = 1'b0;
      model_write(8'h0, 32'hA5A5_0001, 4'hF);
      awaddr = 8'h0; wdata = 32'hA5A5_0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      begin
         int n = 0;
         do begin @(posedge ACLK); #1; n++; end while (!AWREADY && n < 20);
         if (!AWREADY) fail("bp_first_accept_timeout");
      end
      @(posedge ACLK); #1;
      model_write(8'h4, 32'h5A5A_0002, 4'hF);
      awaddr = 8'h4; wdata = 32'h5A5A_0002;
      for (int i = 0; i < 10; i++) begin
         @(posedge ACLK); #1;
         chk("bp_bvalid_held", BVALID, 1);
         chk("bp_no_second_accept", {AWREADY, WREADY}, 0);
      end
      bready = 1'b1;
      @(posedge ACLK); #1;
      chk("bp_not_yet_after_b", AWREADY, 0);
      @(posedge ACLK); #1;
      chk("bp_accept_after_b", {AWREADY, WREADY}, 2'b11);
      @(posedge ACLK); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      repeat (2) @(posedge ACLK); #1;
      chk("bp_params", {param1, param0}, {32'h5A5A_0002, 32'hA5A5_0001});

      // read and write of 0xC handshake on the same edge
      model_read(8'hC);
      model_write(8'hC, 32'hDEAD_BEEF, 4'hF);
      fork
         do_write(8'hC, 32'hDEAD_BEEF, 4'hF, 0);
         do_read(8'hC);
      join
      rd(8'hC);

      wr(8'h10, 32'hCAFE_F00D, 4'hF, 0);
      rd(8'h10);
      wr(8'h8, 32'h7777_7777, 4'h0, 1);

      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0) wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
         else rd(a);
      end

      // reset in the middle of a read response
      rready = 1'b0;
      araddr = 8'h4; arvalid = 1'b1;
      begin
         int n = 0;
         do begin @(posedge ACLK); #1; n++; end while (!ARREADY && n < 20);
         if (!ARREADY) fail("rst_read_accept_timeout");
      end
      @(posedge ACLK); #1;
      arvalid = 1'b0;
      chk("rst_read_rvalid_up", RVALID, 1);
      ARESET = 1'b1;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
      chk("rst_mid_read_rvalid", RVALID, 0);
      chk("rst_mid_read_params", {param3, param2, param1, param0}, 0);
      rready = 1'b1;
      repeat (3) @(posedge ACLK); #1;
      chk("rst_no_late_resp", {BVALID, RVALID}, 0);

      chk("b_queue_drained", 32'(exp_b.size()), 0);
      chk("r_queue_drained", 32'(exp_r.size()), 0);
      chk("upd_queue_drained", 32'(exp_upd.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/axi_tremolo_param_regs.md
# axi_tremolo_param_regs

AXI4-Lite slave register file holding the four 32-bit tremolo parameter registers. It is the responder the AXI VIP master bench drives. It terminates AXI4-Lite write and read transactions from the PS/VIP master, stores parameters with byte-strobe granularity, and presents them to the tremolo datapath. It also emits a one-cycle update strobe per register so the datapath can reload its LFO/gain state.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; must be ≥4. Bits [3:2] select the register and bits [1:0] are ignored.
- ACLK in 1: sole clock; all logic is on the rising edge.
- ARESET in 1: synchronous, active-high reset.
- S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1
- S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1
- param0..param3 out 32 each: current register contents (0x0, 0x4, 0x8, 0xC).
- param_upd out 4: bit n pulses high for one cycle after any byte of register n is written.

## Operation
- Register map: 0x0 param0, 0x4 param1, 0x8 param2, 0xC param3. All registers are full 32-bit read/write. A read returns exactly the last value written.
- Address bits above [3] nonzero marks an out-of-range access:
  - write: no register changes, BRESP=SLVERR (2'b10).
  - read: RDATA=0, RRESP=SLVERR.
  - In-range accesses respond OKAY (2'b00).
- Write FSM has two states:
  - W_IDLE: AWVALID and WVALID both sampled high (any arrival order, same or different cycles). The block waits until both are valid and never accepts one without the other.
  - W_RESP: BVALID held high until BREADY is sampled high, then return to W_IDLE.
- Byte lanes: for each WSTRB[k]=1, reg[8k+7:8k] takes WDATA[8k+7:8k]. Other lanes are kept. With WSTRB=0 the write completes with OKAY, changes nothing, and raises no param_upd.
- Read FSM has two states:
  - R_IDLE: ARVALID sampled high.
  - R_DATA: RVALID held high with RDATA/RRESP stable until RREADY is sampled high, then return to R_IDLE.
- The read and write channels are fully independent. One outstanding transaction per channel.

## Timing
- Reset values: all params 0, param_upd 0, AWREADY/WREADY/BVALID/ARREADY/RVALID 0, BRESP/RRESP/RDATA 0. Reset mid-transaction aborts it; no response is issued after reset.
- Write path, with AWVALID&&WVALID first sampled high at edge N in W_IDLE:
  - AWREADY=WREADY=1 for exactly cycle N..N+1.
  - The register is updated at edge N+1 (handshake edge).
  - BVALID rises after edge N+1; earliest BVALID/BREADY completion is edge N+2.
  - param_upd[n] is high for the cycle after edge N+1.
  - Minimum write spacing is 3 cycles with BREADY tied high.
- Read path, with ARVALID sampled at edge M in R_IDLE:
  - ARREADY is high for one cycle.
  - RDATA is captured at handshake edge M+1; RVALID rises after M+1.
  - Minimum read spacing is 3 cycles with RREADY tied high.
- Simultaneous read and write handshake to the same register on the same edge: the read returns the pre-write value.
- Backpressure: while BVALID or RVALID waits on its ready, the corresponding READYs stay 0. AWVALID/WVALID/ARVALID may stay high without a second acceptance.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC with WSTRB=0xF, then reads of the same addresses.
  - Every BRESP and RRESP is OKAY; RDATA is 0x1..0x4.
  - param0..3 equal 0x1..0x4; param_upd pulses bits 0..3 once each.
- Write 0xFFFFFFFF to 0x4, then 0x000000AA to 0x4 with WSTRB=0x1 -> read 0x4 returns 0xFFFFFFAA.
- WVALID raised 5 cycles after AWVALID on a write to 0x8 of 0x12345678.
  - AWREADY is not asserted before WVALID.
  - The single handshake stores 0x12345678; BVALID rises only after the handshake.
- BREADY held low for 10 cycles after a write:
  - BVALID stays high.
  - A second AW/W presented meanwhile is not accepted until the cycle after the B handshake.
- Read 0xC, write 0xDEADBEEF to 0xC, with both handshakes on the same edge and the register previously 0x4:
  - RDATA=0x4.
  - A subsequent read returns 0xDEADBEEF.
- With C_S_AXI_ADDR_WIDTH=8, write to 0x10:
  - BRESP=SLVERR, no param change, no param_upd.
  - Read 0x10 returns RDATA=0 with RRESP=SLVERR.
  - ARESET asserted mid-read clears RVALID and all params to 0.
